hid_report_packer: RTL and testbench

HID_REPORT_PACKER -- requirements
Module: hid_report_packer

---
 rtl/hid_report_packer_if.sv | 24 ++
 rtl/hid_report_packer.sv | 162 ++++++++++++++++
 tb/tb_hid_report_packer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hid_report_packer_if.sv
// Byte stream from the report packer into the endpoint buffer.
// The packer drives as master; the endpoint buffer answers with tx_ready as slave.
interface hid_report_packer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/hid_report_packer.sv
// Accumulates relative mouse motion and button state between host polls.
// Each poll is answered with a 3-byte boot-style report {buttons, dx, dy}, or with a NAK.
module hid_report_packer #(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     rpt_valid,
    input  logic signed [DATA_W-1:0] rpt_dx,
    input  logic signed [DATA_W-1:0] rpt_dy,
    input  logic [2:0]               rpt_buttons,
    input  logic                     in_token,
    hid_report_packer_if.master      tx,
    output logic                     nak,
    output logic                     sat,
    output logic                     busy
);

    // Symmetric clamp range keeps -128 out of the report (e.g. +/-127 for 8-bit).
    localparam logic signed [DATA_W:0] LIM_HI = (DATA_W+1)'((1 << (DATA_W-1)) - 1);
    localparam logic signed [DATA_W:0] LIM_LO = -LIM_HI;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B0   = 2'd1,
        B1   = 2'd2,
        B2   = 2'd3
    } state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] acc_x;
    logic signed [DATA_W-1:0] acc_y;
    logic [2:0]               btn_cur;
    logic [2:0]               btn_sent;
    logic signed [DATA_W-1:0] snap_x;
    logic signed [DATA_W-1:0] snap_y;

    logic                     pending;
    logic                     poll_idle;
    logic                     take_snap;
    logic                     give_nak;
    logic signed [DATA_W-1:0] base_x;
    logic signed [DATA_W-1:0] base_y;
    logic signed [DATA_W:0]   sum_x;
    logic signed [DATA_W:0]   sum_y;

    function automatic logic signed [DATA_W-1:0] clamp_sym(input logic signed [DATA_W:0] v);
        if (v > LIM_HI) begin
            return LIM_HI[DATA_W-1:0];
        end else if (v < LIM_LO) begin
            return LIM_LO[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    function automatic logic clamps(input logic signed [DATA_W:0] v);
        return (v > LIM_HI) || (v < LIM_LO);
    endfunction

    always_comb begin
        pending   = (acc_x != '0) || (acc_y != '0) || (btn_cur != btn_sent);
        poll_idle = in_token && (state == IDLE);
        take_snap = poll_idle && enable && pending;
        give_nak  = poll_idle && !(enable && pending);
        // A sample landing in the snapshot cycle starts the next report from zero.
        base_x    = take_snap ? '0 : acc_x;
        base_y    = take_snap ? '0 : acc_y;
        sum_x     = {base_x[DATA_W-1], base_x} + {rpt_dx[DATA_W-1], rpt_dx};
        sum_y     = {base_y[DATA_W-1], base_y} + {rpt_dy[DATA_W-1], rpt_dy};
    end

    // Motion accumulation, button tracking and report snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_x    <= '0;
            acc_y    <= '0;
            btn_cur  <= '0;
            btn_sent <= '0;
            snap_x   <= '0;
            snap_y   <= '0;
            sat      <= 1'b0;
        end else if (!enable) begin
            acc_x    <= '0;
            acc_y    <= '0;
            btn_sent <= btn_cur;
            sat      <= 1'b0;
        end else begin
            sat <= rpt_valid && (clamps(sum_x) || clamps(sum_y));
            if (rpt_valid) begin
                acc_x   <= clamp_sym(sum_x);
                acc_y   <= clamp_sym(sum_y);
                btn_cur <= rpt_buttons;
            end else if (take_snap) begin
                acc_x <= '0;
                acc_y <= '0;
            end
            if (take_snap) begin
                snap_x   <= acc_x;
                snap_y   <= acc_y;
                btn_sent <= btn_cur;
            end
        end
    end

    // Report byte sequencer; byte 0 is loaded straight from btn_cur at snapshot time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            nak         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            nak <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_snap) begin
                        state       <= B0;
                        tx.tx_data  <= {{(DATA_W-3){1'b0}}, btn_cur};
                        tx.tx_valid <= 1'b1;
                        tx.tx_last  <= 1'b0;
                        busy        <= 1'b1;
                    end else if (give_nak) begin
                        nak <= 1'b1;
                    end
                end
                B0: begin
                    if (tx.tx_ready) begin
                        state      <= B1;
                        tx.tx_data <= snap_x;
                    end
                end
                B1: begin
                    if (tx.tx_ready) begin
                        state      <= B2;
                        tx.tx_data <= snap_y;
                        tx.tx_last <= 1'b1;
                    end
                end
                B2: begin
                    if (tx.tx_ready) begin
                        state       <= IDLE;
                        tx.tx_data  <= '0;
                        tx.tx_valid <= 1'b0;
                        tx.tx_last  <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    tx.tx_valid <= 1'b0;
                    tx.tx_last  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hid_report_packer.sv
// Bench for hid_report_packer: directed scenarios plus random traffic, scored against
// a behavioural model of the accumulate/poll/report rules.
module tb_hid_report_packer;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              rpt_valid = 1'b0;
    logic signed [7:0] rpt_dx = '0;
    logic signed [7:0] rpt_dy = '0;
    logic [2:0]        rpt_buttons = '0;
    logic              in_token = 1'b0;
    logic              nak;
    logic              sat;
    logic              busy;

    hid_report_packer_if #(.DATA_W(8)) txi ();

    hid_report_packer #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rpt_valid   (rpt_valid),
        .rpt_dx      (rpt_dx),
        .rpt_dy      (rpt_dy),
        .rpt_buttons (rpt_buttons),
        .in_token    (in_token),
        .tx          (txi.master),
        .nak         (nak),
        .sat         (sat),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_nak;
        bit [7:0] data;
        bit       last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (plain integers)
    int ax = 0, ay = 0, bcur = 0, bsent = 0;
    int rem = 0;
    int exp_sat = 0;
    int sat_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp127(input int v);
        if (v > 127) return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    function automatic bit out_of_range(input int v);
        return (v > 127) || (v < -127);
    endfunction

    task automatic push_byte(input int d, input bit last);
        exp_t e;
        e.is_nak = 1'b0;
        e.data   = d[7:0];
        e.last   = last;
        q.push_back(e);
    endtask

    task automatic push_nak();
        exp_t e;
        e.is_nak = 1'b1;
        e.data   = '0;
        e.last   = 1'b0;
        q.push_back(e);
    endtask

    // One clock edge of the model: what the block must do with these inputs.
    task automatic model_edge(input bit en, input bit rv, input int dx, input int dy,
                              input int b, input bit tok, input bit rdy);
        bit idle;
        bit snap;
        int sx, sy;
        idle = (rem == 0);
        snap = 1'b0;
        if (rem > 0 && rdy) rem--;
        if (tok && idle) begin
            if (!en || !(ax != 0 || ay != 0 || bcur != bsent)) begin
                push_nak();
            end else begin
                push_byte(bcur, 1'b0);
                push_byte(ax, 1'b0);
                push_byte(ay, 1'b1);
                rem   = 3;
                bsent = bcur;
                snap  = 1'b1;
            end
        end
        if (!en) begin
            ax    = 0;
            ay    = 0;
            bsent = bcur;
        end else begin
            if (snap) begin
                ax = 0;
                ay = 0;
            end
            if (rv) begin
                sx = ax + dx;
                sy = ay + dy;
                if (out_of_range(sx) || out_of_range(sy)) exp_sat++;
                ax   = clamp127(sx);
                ay   = clamp127(sy);
                bcur = b;
            end
        end
    endtask

    task automatic step(input bit en, input bit rv, input int dx, input int dy,
                        input int b, input bit tok, input bit rdy);
        @(posedge clk);
        #1;
        check("busy", busy, (rem > 0) ? 1 : 0);
        enable       = en;
        rpt_valid    = rv;
        rpt_dx       = 8'(dx);
        rpt_dy       = 8'(dy);
        rpt_buttons  = 3'(b);
        in_token     = tok;
        txi.tx_ready = rdy;
        model_edge(en, rv, dx, dy, b, tok, rdy);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, bcur, 0, 1);
    endtask

    task automatic sample(input int dx, input int dy, input int b);
        step(1, 1, dx, dy, b, 0, 1);
    endtask

    task automatic poll();
        step(1, 0, 0, 0, bcur, 1, 1);
    endtask

    // Scoreboard monitor
    bit       stall_prev = 1'b0;
    bit [7:0] prev_data;
    bit       prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", txi.tx_valid, 1);
                check("hold_data", txi.tx_data, prev_data);
                check("hold_last", txi.tx_last, prev_last);
            end
            stall_prev = txi.tx_valid && !txi.tx_ready;
            prev_data  = txi.tx_data;
            prev_last  = txi.tx_last;
            if (txi.tx_valid && txi.tx_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_byte", txi.tx_data, -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("byte_kind", 0, e.is_nak);
                    check("tx_data", txi.tx_data, e.data);
                    check("tx_last", txi.tx_last, e.last);
                end
            end
            if (nak) begin
                if (q.size() == 0) begin
                    check("unexpected_nak", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("nak_kind", 1, e.is_nak);
                end
            end
            if (sat) sat_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        txi.tx_ready = 1'b0;
        #12;
        check("rst_tx_valid", txi.tx_valid, 0);
        check("rst_tx_data", txi.tx_data, 0);
        check("rst_tx_last", txi.tx_last, 0);
        check("rst_nak", nak, 0);
        check("rst_sat", sat, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Poll with nothing accumulated
        poll();
        idle_steps(3);

        // Basic report: 0x01, 0x05, 0xFD
        sample(5, -3, 1);
        poll();
        idle_steps(5);

        // Saturation, then an empty second poll
        for (int i = 0; i < 20; i++) sample(10, -10, 1);
        poll();
        idle_steps(5);
        poll();
        idle_steps(3);

        // Button-only changes
        sample(0, 0, 1);
        idle_steps(1);
        poll();
        idle_steps(5);
        sample(0, 0, 0);
        poll();
        idle_steps(5);

        // Stall in B1 with a sample arriving during the stall
        sample(3, 1, 0);
        poll();
        step(1, 0, 0, 0, bcur, 0, 1);
        step(1, 0, 0, 0, bcur, 0, 0);
        step(1, 1, 7, 0, bcur, 0, 0);
        step(1, 0, 0, 0, bcur, 0, 0);
        idle_steps(4);
        poll();
        idle_steps(5);

        // Sample coincident with the poll goes to the next report
        sample(4, 0, 0);
        step(1, 1, 2, 0, 0, 1, 1);
        idle_steps(5);
        poll();
        idle_steps(5);

        // Enable low: samples ignored, poll NAKed, in-flight transfer completes
        sample(9, 9, 2);
        poll();
        step(0, 1, 5, 5, 4, 0, 0);
        step(0, 1, 5, 5, 4, 1, 1);
        step(0, 0, 0, 0, bcur, 0, 1);
        step(0, 0, 0, 0, bcur, 0, 1);
        step(0, 0, 0, 0, bcur, 1, 1);
        idle_steps(3);
        poll();
        idle_steps(3);

        // Reset in the middle of a report
        sample(6, 6, 3);
        poll();
        step(1, 0, 0, 0, bcur, 0, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_valid", txi.tx_valid, 0);
        check("rst_mid_busy", busy, 0);
        q.delete();
        ax = 0; ay = 0; bcur = 0; bsent = 0; rem = 0;
        enable = 1'b1; rpt_valid = 1'b0; in_token = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        poll();
        idle_steps(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit en, rv, tok, rdy;
            int dx, dy, b;
            en  = ($urandom_range(0, 15) != 0);
            rv  = ($urandom_range(0, 2) == 0);
            tok = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            dx  = int'($urandom_range(0, 255)) - 128;
            dy  = int'($urandom_range(0, 255)) - 128;
            b   = int'($urandom_range(0, 7));
            step(en, rv, dx, dy, b, tok, rdy);
        end

        for (int i = 0; i < 40 && (q.size() != 0 || rem != 0); i++) idle_steps(1);
        idle_steps(2);
        check("queue_drained", q.size(), 0);
        check("sat_pulses", sat_seen, exp_sat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
